// File: rtl/code_entry_verifier.sv
// rtl/code_entry_verifier.sv - serial code entry, four-mode verification, timed result and failure lockout
module code_entry_verifier #(
   parameter int CODE_W     = 8,
   parameter int CHECK_W    = 4,
   parameter int RESULT_CYC = 4,
   parameter int MAX_TRIES  = 3,
   parameter int LOCK_CYC   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             btn_one,
   input  logic                             btn_zero,
   input  logic                             btn_check,
   input  logic [1:0]                       mode,
   input  logic [CODE_W-1:0]                key,
   output logic [CODE_W-1:0]                code,
   output logic [$clog2(CODE_W+1)-1:0]      bit_count,
   output logic                             waiting_for_user,
   output logic                             verifying,
   output logic                             done,
   output logic                             pass,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
   output logic                             locked
);

   localparam int BC_W    = $clog2(CODE_W + 1);
   localparam int FC_W    = $clog2(MAX_TRIES + 1);
   localparam int CNT_MAX = (RESULT_CYC > LOCK_CYC) ? RESULT_CYC : LOCK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {ENTRY, VERIFY, RESULT, LOCKED} state_t;

   state_t             state;
   logic [CNT_W-1:0]   timer;
   logic               one_prev, zero_prev, check_prev;
   logic               one_edge, zero_edge, check_edge;
   logic               result;

   assign one_edge   = btn_one & ~one_prev;
   assign zero_edge  = btn_zero & ~zero_prev;
   assign check_edge = btn_check & ~check_prev;

   assign waiting_for_user = (state == ENTRY);
   assign verifying        = (state == VERIFY);

   always_comb begin
      result = 1'b0;
      case (mode)
         2'd0:    result = (code[CHECK_W-1:0] == key[CHECK_W-1:0]);
         2'd1:    result = (code == key);
         2'd2:    result = ~(^code);
         default: result = (code >= key);
      endcase
   end

   // The timer is shared: RESULT hold length, then lockout length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ENTRY;
         code       <= '0;
         bit_count  <= '0;
         fail_count <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         locked     <= 1'b0;
         timer      <= '0;
         one_prev   <= 1'b0;
         zero_prev  <= 1'b0;
         check_prev <= 1'b0;
      end else begin
         one_prev   <= btn_one;
         zero_prev  <= btn_zero;
         check_prev <= btn_check;
         case (state)
            ENTRY: begin
               if (check_edge && bit_count == BC_W'(CODE_W)) begin
                  state <= VERIFY;
               end else if (one_edge ^ zero_edge) begin
                  code <= {code[CODE_W-2:0], one_edge};
                  if (bit_count != BC_W'(CODE_W))
                     bit_count <= bit_count + BC_W'(1);
               end
            end
            VERIFY: begin
               pass  <= result;
               done  <= 1'b1;
               timer <= CNT_W'(RESULT_CYC - 1);
               state <= RESULT;
               if (result)
                  fail_count <= '0;
               else if (fail_count != FC_W'(MAX_TRIES))
                  fail_count <= fail_count + FC_W'(1);
            end
            RESULT: begin
               if (timer == '0) begin
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  code      <= '0;
                  bit_count <= '0;
                  if (fail_count == FC_W'(MAX_TRIES)) begin
                     locked <= 1'b1;
                     timer  <= CNT_W'(LOCK_CYC - 1);
                     state  <= LOCKED;
                  end else begin
                     state <= ENTRY;
                  end
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end
            default: begin
               if (timer == '0) begin
                  locked     <= 1'b0;
                  fail_count <= '0;
                  state      <= ENTRY;
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_code_entry_verifier.sv
// tb/tb_code_entry_verifier.sv - directed self-checking bench for code_entry_verifier
module tb_code_entry_verifier;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_one, btn_zero, btn_check;
   logic [1:0] mode;
   logic [7:0] key;
   logic [7:0] code;
   logic [3:0] bit_count;
   logic       waiting_for_user, verifying, done, pass, locked;
   logic [1:0] fail_count;

   int checks = 0;
   int failures = 0;

   code_entry_verifier dut (
      .clk(clk), .rst(rst), .btn_one(btn_one), .btn_zero(btn_zero),
      .btn_check(btn_check), .mode(mode), .key(key), .code(code),
      .bit_count(bit_count), .waiting_for_user(waiting_for_user),
      .verifying(verifying), .done(done), .pass(pass),
      .fail_count(fail_count), .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic b);
      if (b) btn_one = 1'b1; else btn_zero = 1'b1;
      tick();
      btn_one = 1'b0;
      btn_zero = 1'b0;
      tick();
   endtask

   task automatic enter_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) press(v[i]);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_code"}, code, 8'h00);
      check({tag, "_bc"}, bit_count, 4'd0);
      check({tag, "_fc"}, fail_count, 2'd0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_pass"}, pass, 1'b0);
      check({tag, "_locked"}, locked, 1'b0);
      check({tag, "_verifying"}, verifying, 1'b0);
      check({tag, "_waiting"}, waiting_for_user, 1'b1);
   endtask

   task automatic do_check(input string tag, input logic exp_pass,
                           input logic [1:0] exp_fc, input logic exp_lock);
      btn_check = 1'b1;
      tick();
      check({tag, "_verifying"}, verifying, 1'b1);
      check({tag, "_waiting_v"}, waiting_for_user, 1'b0);
      btn_check = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check({tag, "_done_hold"}, done, 1'b1);
         check({tag, "_pass_hold"}, pass, exp_pass);
         check({tag, "_fc_hold"}, fail_count, exp_fc);
         tick();
      end
      check({tag, "_done_end"}, done, 1'b0);
      check({tag, "_pass_end"}, pass, 1'b0);
      check({tag, "_code_end"}, code, 8'h00);
      check({tag, "_bc_end"}, bit_count, 4'd0);
      check({tag, "_fc_end"}, fail_count, exp_fc);
      check({tag, "_locked_end"}, locked, exp_lock);
      check({tag, "_waiting_end"}, waiting_for_user, !exp_lock);
   endtask

   initial begin
      rst = 1'b1;
      btn_one = 1'b0; btn_zero = 1'b0; btn_check = 1'b0;
      mode = 2'd0; key = 8'h0C;
      #1;
      check_reset_state("reset");
      tick();
      rst = 1'b0;
      tick();

      // nine entries slide to 8'h8C, mode 0 compares low nibble
      press(1); press(1); press(0); press(0); press(0);
      press(1); press(1); press(0); press(0);
      check("t1_code", code, 8'h8C);
      check("t1_bc", bit_count, 4'd8);
      do_check("t1", 1'b1, 2'd0, 1'b0);

      mode = 2'd1; key = 8'h8D;
      enter_byte(8'h8C);
      do_check("t2_eq", 1'b0, 2'd1, 1'b0);
      mode = 2'd3; key = 8'h80;
      enter_byte(8'h8C);
      do_check("t2_ge", 1'b1, 2'd0, 1'b0);

      mode = 2'd2;
      enter_byte(8'hA5);
      check("par_code", code, 8'hA5);
      do_check("par_even", 1'b1, 2'd0, 1'b0);
      enter_byte(8'hA4);
      do_check("par_odd", 1'b0, 2'd1, 1'b0);

      // asynchronous reset in the middle of RESULT
      mode = 2'd1; key = 8'hFF;
      enter_byte(8'h00);
      btn_check = 1'b1;
      tick();
      btn_check = 1'b0;
      tick();
      check("rr_done_pre", done, 1'b1);
      check("rr_fc_pre", fail_count, 2'd2);
      #2 rst = 1'b1;
      #1;
      check_reset_state("rst_result");
      tick();
      rst = 1'b0;
      tick();

      // partial entry, held button, simultaneous buttons
      press(1); press(0); press(1); press(1); press(0);
      btn_check = 1'b1;
      tick();
      btn_check = 1'b0;
      tick();
      check("part_waiting", waiting_for_user, 1'b1);
      check("part_verifying", verifying, 1'b0);
      check("part_bc", bit_count, 4'd5);
      check("part_code", code, 8'h16);
      btn_one = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      btn_one = 1'b0;
      tick();
      check("held_bc", bit_count, 4'd6);
      check("held_code", code, 8'h2D);
      btn_one = 1'b1; btn_zero = 1'b1;
      tick();
      btn_one = 1'b0; btn_zero = 1'b0;
      tick();
      check("both_code", code, 8'h2D);
      check("both_bc", bit_count, 4'd6);

      // three consecutive failures lead to lockout
      mode = 2'd1; key = 8'hFF;
      enter_byte(8'h00);
      do_check("lk1", 1'b0, 2'd1, 1'b0);
      enter_byte(8'h00);
      do_check("lk2", 1'b0, 2'd2, 1'b0);
      enter_byte(8'h00);
      do_check("lk3", 1'b0, 2'd3, 1'b1);
      for (int i = 0; i < 15; i++) begin
         btn_one = (i % 2 == 0);
         btn_check = (i % 3 == 0);
         tick();
         check("lock_hold", locked, 1'b1);
         check("lock_bc", bit_count, 4'd0);
         check("lock_code", code, 8'h00);
      end
      btn_one = 1'b0; btn_check = 1'b0;
      tick();
      check("unlock_locked", locked, 1'b0);
      check("unlock_fc", fail_count, 2'd0);
      check("unlock_waiting", waiting_for_user, 1'b1);
      check("unlock_bc", bit_count, 4'd0);

      // asynchronous reset in the middle of LOCKED
      for (int n = 0; n < 3; n++) begin
         enter_byte(8'h00);
         btn_check = 1'b1;
         tick();
         btn_check = 1'b0;
         for (int i = 0; i < 5; i++) tick();
      end
      for (int i = 0; i < 4; i++) tick();
      check("rl_locked_pre", locked, 1'b1);
      check("rl_fc_pre", fail_count, 2'd3);
      #2 rst = 1'b1;
      #1;
      check_reset_state("rst_locked");
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_waiting", waiting_for_user, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
